// File: rtl/ddr5_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : ddr5_req_queue
// Purpose  : DDR5 request queue. Splits each request address into
//            channel / bank-group / bank / row / column fields, keeps up to
//            DEPTH requests in age order in a circular buffer, issues them
//            in order or oldest-ready-first, and retires them in order.
// Ports    : clock, reset                 sole clock, sync active-high reset
//            in_valid/in_ready/in_addr/in_op    enqueue handshake + request
//            ch_busy                      per-channel issue block
//            iss_valid/iss_ready/iss_*    issue handshake + mapped fields
//            done_valid/done_tag/done_err completion marking + error pulse
//            pop_valid/pop_tag            retirement pulse
//            count/full/empty             occupancy
// Revision : 1.0 - initial release
// ============================================================================
module ddr5_req_queue #(
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 34,
   parameter int BYTE_W     = 2,
   parameter int COL_LO_W   = 4,
   parameter int CH_W       = 1,
   parameter int BG_W       = 3,
   parameter int BA_W       = 2,
   parameter int COL_HI_W   = 6,
   parameter int ISSUE_MODE = 0,
   localparam int TAG_W     = $clog2(DEPTH),
   localparam int ROW_W     = ADDR_W - BYTE_W - COL_LO_W - CH_W - BG_W - BA_W - COL_HI_W,
   localparam int COL_W     = COL_HI_W + COL_LO_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [1:0]           in_op,
   input  logic [2**CH_W-1:0]   ch_busy,
   output logic                 iss_valid,
   input  logic                 iss_ready,
   output logic [TAG_W-1:0]     iss_tag,
   output logic [1:0]           iss_op,
   output logic [CH_W-1:0]      iss_ch,
   output logic [BG_W-1:0]      iss_bg,
   output logic [BA_W-1:0]      iss_ba,
   output logic [ROW_W-1:0]     iss_row,
   output logic [COL_W-1:0]     iss_col,
   input  logic                 done_valid,
   input  logic [TAG_W-1:0]     done_tag,
   output logic                 done_err,
   output logic                 pop_valid,
   output logic [TAG_W-1:0]     pop_tag,
   output logic [TAG_W:0]       count,
   output logic                 full,
   output logic                 empty
);

   // Field LSB positions, contiguous from the address LSB.
   localparam int c_col_lo_lsb = BYTE_W;
   localparam int c_ch_lsb     = c_col_lo_lsb + COL_LO_W;
   localparam int c_bg_lsb     = c_ch_lsb + CH_W;
   localparam int c_ba_lsb     = c_bg_lsb + BG_W;
   localparam int c_col_hi_lsb = c_ba_lsb + BA_W;
   localparam int c_row_lsb    = c_col_hi_lsb + COL_HI_W;

   // Slot lifecycle encoding.
   localparam logic [1:0] c_free = 2'd0;
   localparam logic [1:0] c_pend = 2'd1;
   localparam logic [1:0] c_iss  = 2'd2;
   localparam logic [1:0] c_proc = 2'd3;

   logic [1:0]        r_state [DEPTH];
   logic [1:0]        r_op    [DEPTH];
   logic [CH_W-1:0]   r_ch    [DEPTH];
   logic [BG_W-1:0]   r_bg    [DEPTH];
   logic [BA_W-1:0]   r_ba    [DEPTH];
   logic [ROW_W-1:0]  r_row   [DEPTH];
   logic [COL_W-1:0]  r_col   [DEPTH];

   logic [TAG_W-1:0]  r_head;
   logic [TAG_W-1:0]  r_tail;
   logic [TAG_W:0]    r_count;
   logic              r_done_err;

   logic [TAG_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_sel;
   logic              w_sel_ok;
   logic              w_seen;
   logic              w_enq;
   logic              w_iss;
   logic              w_done_ok;
   logic              w_pop;
   logic [1:0]        w_op;
   logic              w_unused_byte;

   // The byte-within-word bits carry no information for the DRAM command.
   assign w_unused_byte = ^in_addr[BYTE_W-1:0];

   // Opcode 3 is illegal and is downgraded to a read.
   assign w_op = (in_op == 2'd3) ? 2'd0 : in_op;

   // Age-ordered scan from head. In strict mode the oldest pending entry
   // gates everything behind it; in oldest-ready mode busy channels are
   // skipped.
   always_comb begin
      w_idx    = r_head;
      w_sel    = r_head;
      w_sel_ok = 1'b0;
      w_seen   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + TAG_W'(i);
         if (!w_seen && r_state[w_idx] == c_pend) begin
            if (ISSUE_MODE == 0) begin
               w_seen   = 1'b1;
               w_sel    = w_idx;
               w_sel_ok = !ch_busy[r_ch[w_idx]];
            end else if (!ch_busy[r_ch[w_idx]]) begin
               w_seen   = 1'b1;
               w_sel    = w_idx;
               w_sel_ok = 1'b1;
            end
         end
      end
   end

   assign full      = (r_count == (TAG_W+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign in_ready  = !full;

   assign iss_valid = w_sel_ok && !reset;
   assign iss_tag   = w_sel;
   assign iss_op    = r_op[w_sel];
   assign iss_ch    = r_ch[w_sel];
   assign iss_bg    = r_bg[w_sel];
   assign iss_ba    = r_ba[w_sel];
   assign iss_row   = r_row[w_sel];
   assign iss_col   = r_col[w_sel];

   // A PROCESSED head lasts exactly one cycle, so its decode is the pulse.
   assign w_pop     = (r_state[r_head] == c_proc);
   assign pop_valid = w_pop && !reset;
   assign pop_tag   = r_head;
   assign done_err  = r_done_err;

   assign w_enq     = in_valid && !full;
   assign w_iss     = iss_valid && iss_ready;
   assign w_done_ok = done_valid && (r_state[done_tag] == c_iss);

   // Enqueue (FREE), issue (PENDING), done (ISSUED) and pop (PROCESSED)
   // each touch a slot in a different state, so their writes never collide.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_done_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i] <= c_free;
         end
      end else begin
         if (w_enq) begin
            r_state[r_tail] <= c_pend;
            r_op[r_tail]    <= w_op;
            r_ch[r_tail]    <= in_addr[c_ch_lsb +: CH_W];
            r_bg[r_tail]    <= in_addr[c_bg_lsb +: BG_W];
            r_ba[r_tail]    <= in_addr[c_ba_lsb +: BA_W];
            r_row[r_tail]   <= in_addr[c_row_lsb +: ROW_W];
            r_col[r_tail]   <= {in_addr[c_col_hi_lsb +: COL_HI_W],
                                in_addr[c_col_lo_lsb +: COL_LO_W]};
            r_tail          <= r_tail + TAG_W'(1);
         end
         if (w_iss) begin
            r_state[w_sel] <= c_iss;
         end
         if (w_done_ok) begin
            r_state[done_tag] <= c_proc;
         end
         if (w_pop) begin
            r_state[r_head] <= c_free;
            r_head          <= r_head + TAG_W'(1);
         end
         r_done_err <= done_valid && !w_done_ok;
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + (TAG_W+1)'(1);
            2'b01:   r_count <= r_count - (TAG_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/ddr5_req_queue.md
# ddr5_req_queue

Parametrised, synthesizable DDR5 request queue that sits between the trace/CPU request front end and the DRAM command generator. It accepts memory requests, splits each address into channel/bank-group/bank/row/column fields, and holds up to DEPTH requests in age order. It issues them to the command generator either strictly in order or oldest-ready-first with per-channel blocking. Entries retire strictly in order from the head once marked processed, so completion can arrive out of order.

## Interface
- DEPTH, 16: queue entries, power of two ≥ 2; entry tag = slot index, TAG_W = $clog2(DEPTH)
- ADDR_W, 34: request address width
- BYTE_W / COL_LO_W / CH_W / BG_W / BA_W / COL_HI_W, 2 / 4 / 1 / 3 / 2 / 6: address field widths, LSB upward; ROW_W = ADDR_W − sum = 16
- ISSUE_MODE, 0: 0 = strict in-order issue; 1 = oldest pending entry whose channel is not busy
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1  enqueue handshake
- in_addr  in  ADDR_W  byte address
- in_op  in  2  0 read, 1 write, 2 ifetch; 3 is illegal and treated as read
- ch_busy  in  2**CH_W  per-channel issue block
- iss_valid / iss_ready  out / in  1  issue handshake
- iss_tag  out  TAG_W;  iss_op  out  2;  iss_ch / iss_bg / iss_ba / iss_row  out  field widths
- iss_col  out  COL_HI_W+COL_LO_W  {col_high, col_low}
- done_valid, done_tag  in  1, TAG_W  marks an issued entry processed
- done_err  out  1  one-cycle pulse: done_tag was not ISSUED
- pop_valid, pop_tag  out  1, TAG_W  one-cycle pulse on retirement
- count  out  TAG_W+1;  full, empty  out  1

## Operation
- Address map: byte = a[1:0], col_lo = a[5:2], ch = a[6], bg = a[9:7], ba = a[11:10], col_hi = a[17:12], row = a[33:18]. General rule: contiguous fields in that order from the LSB. The byte field is discarded.
- Storage is a circular buffer with head and tail pointers. Each slot holds the mapped fields, op, and a state.
- Slot states: FREE → PENDING (enqueue) → ISSUED (issue handshake) → PROCESSED (done) → FREE (pop). No other transitions.
- in_ready = !full. An enqueue writes the tail slot as PENDING and advances tail.
- Issue select scans from head toward tail and picks the oldest PENDING entry.
  - Mode 0: if that entry's ch_busy bit is set, iss_valid = 0. A busy channel stalls all later entries.
  - Mode 1: skip PENDING entries whose channel is busy; pick the first eligible one.
  - iss_* are combinational from registered state and ch_busy; they are stable while iss_valid && !iss_ready.
- done_valid with a tag in ISSUED sets that slot to PROCESSED. Any other state leaves the slot unchanged and pulses done_err.
- Retire: if the head slot is PROCESSED, free it, advance head, and pulse pop_valid with pop_tag = old head. At most one retirement per cycle.
- count = occupied slots (PENDING + ISSUED + PROCESSED). full = (count == DEPTH). empty = (count == 0).

## Timing
- Reset values: head = tail = 0, all slots FREE, count 0, empty 1, full 0, in_ready 1, iss_valid 0, pop_valid 0, done_err 0.
- While reset is high, in_valid, iss_ready and done_valid are ignored.
- Reset mid-operation: on the next edge every entry is discarded, with no pop_valid for discarded entries.
- Enqueue at edge N → entry is eligible for iss_valid in cycle N+1. There is no same-cycle bypass.
- Issue handshake at edge N → slot is ISSUED from N+1. Earliest done is in cycle N+1.
- Done at edge N → slot is PROCESSED from N+1. If the slot is the head, pop_valid is high in cycle N+1 and the slot is freed at edge N+1.
- Simultaneous enqueue and pop when full: in_ready is already 0, so the enqueue is refused; the freed slot is usable the next cycle.
- Simultaneous enqueue and pop when not full: both take effect and count is unchanged.
- Simultaneous issue and done in one cycle on different tags: both are applied. done on the tag being issued that same cycle → done_err.
- Pointers wrap modulo DEPTH. Tags are reused after wrap.
- done_err and pop_valid are registered one-cycle pulses.

## Test plan
- Address map: enqueue addr 0x012345678, op 1 → next cycle iss_valid = 1, iss_ch = 1, iss_bg = 4, iss_ba = 1, iss_row = 0x48D, iss_col = 0x5E, iss_op = 1, iss_tag = 0.
- Fill/full: 16 enqueues with iss_ready = 0 → full = 1, in_ready = 0, count = 16; a 17th in_valid is refused. Issue tag 0, done tag 0 → pop_valid with pop_tag = 0 one cycle later; count = 15, in_ready = 1.
- Out-of-order completion: issue tags 0, 1, 2; done 2, then 1 → no pop_valid. Then done 0 → pops of tags 0, 1, 2 on three consecutive cycles.
- Channel blocking: entries A (ch 0) and B (ch 1) queued, ch_busy = 2'b01. With ISSUE_MODE = 0 → iss_valid = 0. With ISSUE_MODE = 1 → B issued with iss_tag = 1; A is issued once ch_busy = 0.
- Errors and wrap: done on a PENDING tag → done_err pulse, state unchanged. Run 40 enqueue/issue/done/pop cycles → tags wrap 15→0, count returns to 0, empty = 1.
- Reset with 5 entries in flight → count 0, iss_valid 0, no pop_valid; a new enqueue gets tag 0.
